// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC event stamper.
//  - Default width/timeout constants used as parameter defaults.
//  - FSM state encoding for the measurement sequencer.
//  - is_busy(): a measurement is in progress in any state other than idle.
package tdc_pkg;

  localparam int unsigned DefaultDataWidth  = 32;
  localparam int unsigned DefaultFineWidth  = 9;
  localparam int unsigned DefaultTimeoutCyc = 1024;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitStart = 2'd1,
    StWaitStop  = 2'd2
  } tdc_state_e;

  function automatic logic is_busy(input tdc_state_e state);
    return (state != StIdle);
  endfunction

endpackage

// File: rtl/tdc_coarse_counter.sv
// Saturating coarse cycle counter for the TDC event stamper.
// Ports:
//  clk_i    : system clock
//  rst_i    : asynchronous active-high reset, counter -> 0
//  clear_i  : restart; the current cycle reads as 0
//  en_i     : advance by one per cycle, sticking at all-ones
//  count_o  : count value belonging to the current cycle
// count_o is the value being registered this cycle, so a hit sampled in the same
// cycle as clear_i stamps 0 and a hit k cycles later stamps k.
module tdc_coarse_counter
  import tdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  output logic [DATA_WIDTH-1:0] count_o
);

  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  saturated;

  assign saturated = &count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !saturated) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_d;

endmodule

// File: rtl/tdc_event_stamper.sv
// Timestamp source for the T0 interval path.
// After an arm request, the first start hit and the following stop hit are each
// stamped with a coarse cycle count (relative to the arm cycle) and their encoded
// fine code, and reported by one-cycle start/stop strobes to the interval calculator.
// Ports:
//  clk_i, rst_i          : system clock, asynchronous active-high reset
//  arm_i                 : one-cycle request to begin a measurement (ignored while busy)
//  start_hit_i/_fine_i   : start strobe and its fine code
//  stop_hit_i/_fine_i    : stop strobe and its fine code
//  start_en_o            : one-cycle pulse, start stamp valid
//  start_coarse_data_o   : coarse stamp of start
//  start_fine_data_o     : fine stamp of start, zero-extended
//  stop_en_o             : one-cycle pulse, stop stamp valid
//  stop_coarse_data_o    : coarse stamp of stop
//  stop_fine_data_o      : fine stamp of stop, zero-extended
//  busy_o                : waiting for start or stop
//  timeout_o             : one-cycle pulse, no stop within TIMEOUT_CYC cycles, aborted
// FINE_WIDTH is expected to be <= DATA_WIDTH.
module tdc_event_stamper
  import tdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned FINE_WIDTH  = DefaultFineWidth,
  parameter int unsigned TIMEOUT_CYC = DefaultTimeoutCyc
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  arm_i,
  input  logic                  start_hit_i,
  input  logic [FINE_WIDTH-1:0] start_fine_i,
  input  logic                  stop_hit_i,
  input  logic [FINE_WIDTH-1:0] stop_fine_i,
  output logic                  start_en_o,
  output logic [DATA_WIDTH-1:0] start_coarse_data_o,
  output logic [DATA_WIDTH-1:0] start_fine_data_o,
  output logic                  stop_en_o,
  output logic [DATA_WIDTH-1:0] stop_coarse_data_o,
  output logic [DATA_WIDTH-1:0] stop_fine_data_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int unsigned         TcntWidth = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TcntWidth-1:0] TcntLimit = TcntWidth'(TIMEOUT_CYC);

  tdc_state_e            state_q, state_d;
  logic [TcntWidth-1:0]  tcnt_q, tcnt_d, tcnt_inc;
  logic                  start_en_q, start_en_d;
  logic                  stop_en_q, stop_en_d;
  logic                  timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0] start_coarse_q, start_coarse_d;
  logic [DATA_WIDTH-1:0] start_fine_q, start_fine_d;
  logic [DATA_WIDTH-1:0] stop_coarse_q, stop_coarse_d;
  logic [DATA_WIDTH-1:0] stop_fine_q, stop_fine_d;

  logic                  cnt_clear;
  logic                  cnt_en;
  logic [DATA_WIDTH-1:0] coarse_now;

  // Kept outside the FSM block so the counter path is not a combinational loop
  // through that block.
  assign cnt_clear = (state_q == StIdle) && arm_i;
  assign cnt_en    = (state_q != StIdle);

  tdc_coarse_counter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_coarse_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .count_o (coarse_now)
  );

  // Counts completed WAIT_STOP cycles; tcnt_inc is the count including this one.
  assign tcnt_inc = tcnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    tcnt_d         = tcnt_q;
    start_en_d     = 1'b0;
    stop_en_d      = 1'b0;
    timeout_d      = 1'b0;
    start_coarse_d = start_coarse_q;
    start_fine_d   = start_fine_q;
    stop_coarse_d  = stop_coarse_q;
    stop_fine_d    = stop_fine_q;

    unique case (state_q)
      StIdle: begin
        // Hits are ignored here, including one coinciding with arm.
        if (arm_i) begin
          state_d = StWaitStart;
        end
      end
      StWaitStart: begin
        // A stop hit before the start has been captured is meaningless; drop it.
        if (start_hit_i) begin
          start_coarse_d = coarse_now;
          start_fine_d   = DATA_WIDTH'(start_fine_i);
          start_en_d     = 1'b1;
          tcnt_d         = '0;
          state_d        = StWaitStop;
        end
      end
      StWaitStop: begin
        tcnt_d = tcnt_inc;
        // Stop on the terminal cycle still counts as a valid measurement.
        if (stop_hit_i) begin
          stop_coarse_d = coarse_now;
          stop_fine_d   = DATA_WIDTH'(stop_fine_i);
          stop_en_d     = 1'b1;
          state_d       = StIdle;
        end else if (tcnt_inc == TcntLimit) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      tcnt_q         <= '0;
      start_en_q     <= 1'b0;
      stop_en_q      <= 1'b0;
      timeout_q      <= 1'b0;
      start_coarse_q <= '0;
      start_fine_q   <= '0;
      stop_coarse_q  <= '0;
      stop_fine_q    <= '0;
    end else begin
      state_q        <= state_d;
      tcnt_q         <= tcnt_d;
      start_en_q     <= start_en_d;
      stop_en_q      <= stop_en_d;
      timeout_q      <= timeout_d;
      start_coarse_q <= start_coarse_d;
      start_fine_q   <= start_fine_d;
      stop_coarse_q  <= stop_coarse_d;
      stop_fine_q    <= stop_fine_d;
    end
  end

  assign start_en_o          = start_en_q;
  assign start_coarse_data_o = start_coarse_q;
  assign start_fine_data_o   = start_fine_q;
  assign stop_en_o           = stop_en_q;
  assign stop_coarse_data_o  = stop_coarse_q;
  assign stop_fine_data_o    = stop_fine_q;
  assign busy_o              = is_busy(state_q);
  assign timeout_o           = timeout_q;

endmodule

// File: tb/tb_tdc_event_stamper.sv
// Scoreboard bench for tdc_event_stamper (DATA_WIDTH=8, FINE_WIDTH=8, TIMEOUT_CYC=16).
// Stimulus pushes the expected pulse (kind, cycle, coarse, fine) into a queue; the
// monitor pops and compares whenever start_en, stop_en or timeout is seen.
module tb_tdc_event_stamper;

  localparam int unsigned DW = 8;
  localparam int unsigned FW = 8;
  localparam int unsigned TO = 16;

  localparam int KStart   = 0;
  localparam int KStop    = 1;
  localparam int KTimeout = 2;

  logic          clk;
  logic          rst;
  logic          arm;
  logic          start_hit;
  logic [FW-1:0] start_fine;
  logic          stop_hit;
  logic [FW-1:0] stop_fine;
  logic          start_en;
  logic [DW-1:0] start_coarse;
  logic [DW-1:0] start_fdata;
  logic          stop_en;
  logic [DW-1:0] stop_coarse;
  logic [DW-1:0] stop_fdata;
  logic          busy;
  logic          timeout;

  tdc_event_stamper #(
    .DATA_WIDTH  (DW),
    .FINE_WIDTH  (FW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .arm_i               (arm),
    .start_hit_i         (start_hit),
    .start_fine_i        (start_fine),
    .stop_hit_i          (stop_hit),
    .stop_fine_i         (stop_fine),
    .start_en_o          (start_en),
    .start_coarse_data_o (start_coarse),
    .start_fine_data_o   (start_fdata),
    .stop_en_o           (stop_en),
    .stop_coarse_data_o  (stop_coarse),
    .stop_fine_data_o    (stop_fdata),
    .busy_o              (busy),
    .timeout_o           (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Period index: inputs driven while cyc==p are sampled at the end of period p,
  // registered outputs from that edge are seen while cyc==p+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;
    int            cyc;
    logic [DW-1:0] coarse;
    logic [DW-1:0] fine;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int c, input logic [DW-1:0] co,
                           input logic [DW-1:0] fi);
    exp_t e;
    e.kind   = kind;
    e.cyc    = c;
    e.coarse = co;
    e.fine   = fi;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int kind, input logic [DW-1:0] co, input logic [DW-1:0] fi);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected pulse: got kind %0d at cycle %0d, required no pulse", kind, cyc);
    end else begin
      e = sb.pop_front();
      check($sformatf("pulse kind (exp cycle %0d)", e.cyc), 64'(kind), 64'(e.kind));
      check($sformatf("pulse cycle kind %0d", kind), 64'(cyc), 64'(e.cyc));
      if (kind != KTimeout) begin
        check($sformatf("coarse kind %0d", kind), 64'(co), 64'(e.coarse));
        check($sformatf("fine kind %0d", kind), 64'(fi), 64'(e.fine));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("start_en/stop_en overlap", 64'(start_en & stop_en), 64'd0);
      if (start_en) pop_check(KStart, start_coarse, start_fdata);
      if (stop_en) pop_check(KStop, stop_coarse, stop_fdata);
      if (timeout) pop_check(KTimeout, '0, '0);
    end
  end

  task automatic drive(input logic a, input logic sh, input logic [FW-1:0] sf,
                       input logic ph, input logic [FW-1:0] pf);
    arm        = a;
    start_hit  = sh;
    start_fine = sf;
    stop_hit   = ph;
    stop_fine  = pf;
    @(posedge clk);
    #1;
    arm        = 1'b0;
    start_hit  = 1'b0;
    start_fine = '0;
    stop_hit   = 1'b0;
    stop_fine  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " start_en"}, 64'(start_en), 64'd0);
    check({tag, " start_coarse"}, 64'(start_coarse), 64'd0);
    check({tag, " start_fine"}, 64'(start_fdata), 64'd0);
    check({tag, " stop_en"}, 64'(stop_en), 64'd0);
    check({tag, " stop_coarse"}, 64'(stop_coarse), 64'd0);
    check({tag, " stop_fine"}, 64'(stop_fdata), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " timeout"}, 64'(timeout), 64'd0);
  endtask

  // arm@t0, start@t0+5 fine 12, stop@t0+15 fine 200 -> coarse 5 / 15.
  task automatic run_basic();
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    check("basic busy after arm", 64'(busy), 64'd1);
    idle(4);
    expect_ev(KStart, cyc + 1, 8'd5, 8'd12);
    drive(1'b0, 1'b1, 8'd12, 1'b0, '0);
    idle(9);
    expect_ev(KStop, cyc + 1, 8'd15, 8'd200);
    drive(1'b0, 1'b0, '0, 1'b1, 8'd200);
    idle(3);
    check("basic held start_coarse", 64'(start_coarse), 64'd5);
    check("basic held start_fine", 64'(start_fdata), 64'd12);
    check("basic held stop_coarse", 64'(stop_coarse), 64'd15);
    check("basic held stop_fine", 64'(stop_fdata), 64'd200);
    check("basic busy at end", 64'(busy), 64'd0);
  endtask

  int s;

  initial begin
    rst        = 1'b1;
    arm        = 1'b0;
    start_hit  = 1'b0;
    start_fine = '0;
    stop_hit   = 1'b0;
    stop_fine  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // 1: basic measurement
    run_basic();

    // 2: timeout 17 clk after start_hit, no stop_en
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    s = cyc;
    expect_ev(KStart, s + 1, 8'd1, 8'd7);
    expect_ev(KTimeout, s + 17, '0, '0);
    drive(1'b0, 1'b1, 8'd7, 1'b0, '0);
    idle(20);
    check("timeout busy after", 64'(busy), 64'd0);
    check("timeout stop_coarse held", 64'(stop_coarse), 64'd15);

    // 2b: stop on the terminal cycle wins over timeout
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    s = cyc;
    expect_ev(KStart, s + 1, 8'd1, 8'd3);
    drive(1'b0, 1'b1, 8'd3, 1'b0, '0);
    idle(15);
    expect_ev(KStop, s + 17, 8'd17, 8'd77);
    drive(1'b0, 1'b0, '0, 1'b1, 8'd77);
    idle(3);
    check("terminal stop busy after", 64'(busy), 64'd0);

    // 3: coincident start/stop -> start only; stop 3 clk later gives start+3
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    idle(2);
    expect_ev(KStart, cyc + 1, 8'd3, 8'd33);
    drive(1'b0, 1'b1, 8'd33, 1'b1, 8'd44);
    idle(2);
    expect_ev(KStop, cyc + 1, 8'd6, 8'd99);
    drive(1'b0, 1'b0, '0, 1'b1, 8'd99);
    idle(3);

    // 4: arm while busy is ignored; hits in idle give nothing
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    idle(1);
    expect_ev(KStart, cyc + 1, 8'd2, 8'd1);
    drive(1'b0, 1'b1, 8'd1, 1'b0, '0);
    idle(2);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    check("arm while busy keeps busy", 64'(busy), 64'd1);
    idle(3);
    expect_ev(KStop, cyc + 1, 8'd9, 8'd2);
    drive(1'b0, 1'b0, '0, 1'b1, 8'd2);
    idle(2);
    drive(1'b0, 1'b1, 8'd5, 1'b0, '0);
    idle(1);
    drive(1'b0, 1'b0, '0, 1'b1, 8'd6);
    idle(3);
    check("idle hits busy", 64'(busy), 64'd0);
    check("idle hits stop_coarse held", 64'(stop_coarse), 64'd9);

    // 4b: arm coinciding with start_hit in idle -> hit ignored
    drive(1'b1, 1'b1, 8'd50, 1'b0, '0);
    idle(1);
    expect_ev(KStart, cyc + 1, 8'd2, 8'd60);
    drive(1'b0, 1'b1, 8'd60, 1'b0, '0);
    idle(1);
    expect_ev(KStop, cyc + 1, 8'd4, 8'd61);
    drive(1'b0, 1'b0, '0, 1'b1, 8'd61);
    idle(3);

    // 5: reset in WAIT_STOP for 2 clk, then a stray stop_hit, then a clean run
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    idle(1);
    expect_ev(KStart, cyc + 1, 8'd2, 8'd10);
    drive(1'b0, 1'b1, 8'd10, 1'b0, '0);
    idle(3);
    rst = 1'b1;
    #2;
    check_all_zero("mid-op reset");
    idle(2);
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1, 8'd11);
    idle(3);
    check_all_zero("after reset release");
    run_basic();

    // 6: saturation at all-ones
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    idle(299);
    expect_ev(KStart, cyc + 1, 8'd255, 8'd0);
    drive(1'b0, 1'b1, 8'd0, 1'b0, '0);
    idle(3);
    expect_ev(KStop, cyc + 1, 8'd255, 8'd255);
    drive(1'b0, 1'b0, '0, 1'b1, 8'd255);
    idle(3);
    check("sat held start_coarse", 64'(start_coarse), 64'd255);
    check("sat held stop_fine", 64'(stop_fdata), 64'd255);

    idle(5);
    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
